// File: rtl/host_wg_inflight_buf.sv
// Host work-group in-flight buffer.
// A request FIFO queues host work-groups. The dispatcher pulls them into a
// table of in-flight slots. Wavefront completions count each slot down.
// A retiring slot pushes its wg_id into a response FIFO that the host drains.
// Optional build macro: WG_BUF_STATS_EN adds the accepted/retired counters.

`ifndef WG_ID_WIDTH
`define WG_ID_WIDTH 15
`endif
`ifndef WF_COUNT_WIDTH
`define WF_COUNT_WIDTH 4
`endif

module host_wg_inflight_buf #(
  parameter int REQ_DEPTH = 4,
  parameter int SLOTS     = 4,
  parameter int CFG_W     = 256,
  parameter int SLOT_W    = $clog2(SLOTS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       host_req_valid_i,
  output logic                       host_req_ready_o,
  input  logic [`WG_ID_WIDTH-1:0]    host_req_wg_id_i,
  input  logic [`WF_COUNT_WIDTH-1:0] host_req_num_wf_i,
  input  logic [CFG_W-1:0]           host_req_cfg_i,
  output logic                       disp_valid_o,
  input  logic                       disp_ready_i,
  output logic [`WG_ID_WIDTH-1:0]    disp_wg_id_o,
  output logic [`WF_COUNT_WIDTH-1:0] disp_num_wf_o,
  output logic [CFG_W-1:0]           disp_cfg_o,
  output logic [SLOT_W-1:0]          disp_slot_o,
  input  logic                       wf_done_valid_i,
  input  logic [SLOT_W-1:0]          wf_done_slot_i,
  output logic                       host_rsp_valid_o,
  input  logic                       host_rsp_ready_i,
  output logic [`WG_ID_WIDTH-1:0]    host_rsp_inflight_wg_buffer_host_wf_done_wg_id_o,
  output logic                       err_o
`ifdef WG_BUF_STATS_EN
  ,
  output logic [31:0]                stat_wg_accepted_o,
  output logic [31:0]                stat_wg_retired_o
`endif
);

  localparam int WGW = `WG_ID_WIDTH;
  localparam int WFW = `WF_COUNT_WIDTH;
  localparam int RPW = $clog2(REQ_DEPTH);

  logic [WGW-1:0]    req_wg_id  [REQ_DEPTH];
  logic [WFW-1:0]    req_num_wf [REQ_DEPTH];
  logic [CFG_W-1:0]  req_cfg    [REQ_DEPTH];
  logic [RPW-1:0]    req_rd, req_wr;
  logic [RPW:0]      req_count;

  logic [SLOTS-1:0]  slot_valid;
  logic [WGW-1:0]    slot_wg_id [SLOTS];
  logic [WFW-1:0]    slot_rem   [SLOTS];

  logic [WGW-1:0]    rsp_wg_id  [SLOTS];
  logic [SLOT_W-1:0] rsp_rd, rsp_wr;
  logic [SLOT_W:0]   rsp_count;

  logic              hold;
  logic [SLOT_W-1:0] held_slot;
  logic              err;

  logic              req_push, req_pop, req_empty, head_zero;
  logic              free_any, disp_fire, done_hit, retire, zero_pop;
  logic              rsp_pop, rsp_push_req, rsp_push, rsp_overflow;
  logic [SLOT_W-1:0] low_free, alloc_slot;
  logic [SLOT_W:0]   valid_cnt;
  logic [WGW-1:0]    rsp_push_id;

  // Lowest free slot and number of busy slots, both from the registered table.
  always_comb begin
    low_free  = '0;
    valid_cnt = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!slot_valid[i]) low_free = SLOT_W'(i);
      valid_cnt = valid_cnt + (SLOT_W + 1)'(slot_valid[i]);
    end
  end

  // Handshake decode; an offered slot is held until the dispatcher takes it so
  // disp_slot_o cannot move when a lower slot retires during back-pressure.
  always_comb begin
    req_empty        = (req_count == '0);
    head_zero        = (req_num_wf[req_rd] == '0);
    free_any         = (slot_valid != '1);
    alloc_slot       = hold ? held_slot : low_free;
    host_req_ready_o = !rst && (req_count != (RPW + 1)'(REQ_DEPTH));
    req_push         = host_req_valid_i && host_req_ready_o;
    disp_valid_o     = !rst && !req_empty && !head_zero && free_any;
    disp_fire        = disp_valid_o && disp_ready_i;
    done_hit         = wf_done_valid_i && slot_valid[wf_done_slot_i];
    retire           = done_hit && (slot_rem[wf_done_slot_i] == WFW'(1));
    zero_pop         = !rst && !req_empty && head_zero && !retire &&
                       (({1'b0, rsp_count} + {1'b0, valid_cnt}) < (SLOT_W + 2)'(SLOTS));
    req_pop          = disp_fire || zero_pop;
    host_rsp_valid_o = !rst && (rsp_count != '0);
    rsp_pop          = host_rsp_valid_o && host_rsp_ready_i;
    rsp_push_req     = retire || zero_pop;
    rsp_push_id      = retire ? slot_wg_id[wf_done_slot_i] : req_wg_id[req_rd];
    // The host not draining responses while new WGs are dispatched can overfill
    // the response queue; such a retirement is dropped and flagged.
    rsp_overflow     = rsp_push_req && (rsp_count == (SLOT_W + 1)'(SLOTS)) && !rsp_pop;
    rsp_push         = rsp_push_req && !rsp_overflow;
    disp_wg_id_o     = disp_valid_o ? req_wg_id[req_rd]  : '0;
    disp_num_wf_o    = disp_valid_o ? req_num_wf[req_rd] : '0;
    disp_cfg_o       = disp_valid_o ? req_cfg[req_rd]    : '0;
    disp_slot_o      = disp_valid_o ? alloc_slot         : '0;
    host_rsp_inflight_wg_buffer_host_wf_done_wg_id_o =
                       host_rsp_valid_o ? rsp_wg_id[rsp_rd] : '0;
    err_o            = err && !rst;
  end

  // Request FIFO storage and pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_rd    <= '0;
      req_wr    <= '0;
      req_count <= '0;
    end else begin
      if (req_push) begin
        req_wg_id[req_wr]  <= host_req_wg_id_i;
        req_num_wf[req_wr] <= host_req_num_wf_i;
        req_cfg[req_wr]    <= host_req_cfg_i;
        req_wr             <= req_wr + 1'b1;
      end
      if (req_pop) req_rd <= req_rd + 1'b1;
      req_count <= req_count + (RPW + 1)'(req_push) - (RPW + 1)'(req_pop);
    end
  end

  // In-flight slot table: allocate on dispatch, count down on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid <= '0;
    end else begin
      if (disp_fire) begin
        slot_valid[alloc_slot] <= 1'b1;
        slot_wg_id[alloc_slot] <= req_wg_id[req_rd];
        slot_rem[alloc_slot]   <= req_num_wf[req_rd];
      end
      if (done_hit) begin
        if (retire) slot_valid[wf_done_slot_i] <= 1'b0;
        else        slot_rem[wf_done_slot_i]   <= slot_rem[wf_done_slot_i] - 1'b1;
      end
    end
  end

  // Response FIFO in retirement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rd    <= '0;
      rsp_wr    <= '0;
      rsp_count <= '0;
    end else begin
      if (rsp_push) begin
        rsp_wg_id[rsp_wr] <= rsp_push_id;
        rsp_wr            <= rsp_wr + 1'b1;
      end
      if (rsp_pop) rsp_rd <= rsp_rd + 1'b1;
      rsp_count <= rsp_count + (SLOT_W + 1)'(rsp_push) - (SLOT_W + 1)'(rsp_pop);
    end
  end

  // Offer hold and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold      <= 1'b0;
      held_slot <= '0;
      err       <= 1'b0;
    end else begin
      hold      <= disp_valid_o && !disp_ready_i;
      held_slot <= alloc_slot;
      if ((wf_done_valid_i && !slot_valid[wf_done_slot_i]) || rsp_overflow) err <= 1'b1;
    end
  end

`ifdef WG_BUF_STATS_EN
  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_wg_accepted_o <= '0;
      stat_wg_retired_o  <= '0;
    end else begin
      if (req_push) stat_wg_accepted_o <= stat_wg_accepted_o + 32'd1;
      if (rsp_push) stat_wg_retired_o  <= stat_wg_retired_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_host_wg_inflight_buf.sv
// Self-checking bench for host_wg_inflight_buf: directed scenarios plus a
// randomized run compared against a queue-based reference model.

`ifndef WG_ID_WIDTH
`define WG_ID_WIDTH 15
`endif
`ifndef WF_COUNT_WIDTH
`define WF_COUNT_WIDTH 4
`endif

module tb_host_wg_inflight_buf;
  localparam int WGW = `WG_ID_WIDTH;
  localparam int WFW = `WF_COUNT_WIDTH;
  localparam int REQ_DEPTH = 4;
  localparam int SLOTS = 4;
  localparam int CFG_W = 256;
  localparam int SLOT_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              host_req_valid_i;
  logic              host_req_ready_o;
  logic [WGW-1:0]    host_req_wg_id_i;
  logic [WFW-1:0]    host_req_num_wf_i;
  logic [CFG_W-1:0]  host_req_cfg_i;
  logic              disp_valid_o;
  logic              disp_ready_i;
  logic [WGW-1:0]    disp_wg_id_o;
  logic [WFW-1:0]    disp_num_wf_o;
  logic [CFG_W-1:0]  disp_cfg_o;
  logic [SLOT_W-1:0] disp_slot_o;
  logic              wf_done_valid_i;
  logic [SLOT_W-1:0] wf_done_slot_i;
  logic              host_rsp_valid_o;
  logic              host_rsp_ready_i;
  logic [WGW-1:0]    rsp_id;
  logic              err_o;
`ifdef WG_BUF_STATS_EN
  logic [31:0]       stat_acc, stat_ret;
`endif

  int total = 0;
  int passed = 0;

  host_wg_inflight_buf #(.REQ_DEPTH(REQ_DEPTH), .SLOTS(SLOTS), .CFG_W(CFG_W)) dut (
    .clk(clk), .rst(rst),
    .host_req_valid_i(host_req_valid_i), .host_req_ready_o(host_req_ready_o),
    .host_req_wg_id_i(host_req_wg_id_i), .host_req_num_wf_i(host_req_num_wf_i),
    .host_req_cfg_i(host_req_cfg_i),
    .disp_valid_o(disp_valid_o), .disp_ready_i(disp_ready_i),
    .disp_wg_id_o(disp_wg_id_o), .disp_num_wf_o(disp_num_wf_o),
    .disp_cfg_o(disp_cfg_o), .disp_slot_o(disp_slot_o),
    .wf_done_valid_i(wf_done_valid_i), .wf_done_slot_i(wf_done_slot_i),
    .host_rsp_valid_o(host_rsp_valid_o), .host_rsp_ready_i(host_rsp_ready_i),
    .host_rsp_inflight_wg_buffer_host_wf_done_wg_id_o(rsp_id),
    .err_o(err_o)
`ifdef WG_BUF_STATS_EN
    , .stat_wg_accepted_o(stat_acc), .stat_wg_retired_o(stat_ret)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    logic [WGW-1:0]   id;
    logic [WFW-1:0]   nwf;
    logic [CFG_W-1:0] cfg;
  } req_t;
  req_t           mq[$];
  logic [WGW-1:0] mrsp[$];
  bit             mv[SLOTS];
  logic [WGW-1:0] mid[SLOTS];
  int             mrem[SLOTS];
  bit             merr;
  bit             have_offer;
  int             offer;

  bit             e_ready, e_disp_valid, e_rsp_valid;
  int             e_slot;

  task automatic idle_inputs();
    host_req_valid_i  = 1'b0;
    host_req_wg_id_i  = '0;
    host_req_num_wf_i = '0;
    host_req_cfg_i    = '0;
    disp_ready_i      = 1'b0;
    wf_done_valid_i   = 1'b0;
    wf_done_slot_i    = '0;
    host_rsp_ready_i  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_req(input logic [WGW-1:0] id, input logic [WFW-1:0] nwf);
    @(negedge clk);
    host_req_valid_i  = 1'b1;
    host_req_wg_id_i  = id;
    host_req_num_wf_i = nwf;
    host_req_cfg_i    = {8{$urandom}};
    @(posedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    total++; if (host_req_ready_o !== 1'b0) $display("FAIL reset_ready got %0b exp 0", host_req_ready_o); else passed++;
    total++; if (disp_valid_o !== 1'b0) $display("FAIL reset_disp_valid got %0b exp 0", disp_valid_o); else passed++;
    total++; if (host_rsp_valid_o !== 1'b0) $display("FAIL reset_rsp_valid got %0b exp 0", host_rsp_valid_o); else passed++;
    total++; if (err_o !== 1'b0) $display("FAIL reset_err got %0b exp 0", err_o); else passed++;
    total++; if ({disp_wg_id_o, disp_num_wf_o, disp_slot_o, rsp_id} !== '0)
      $display("FAIL reset_data got %h exp 0", {disp_wg_id_o, disp_num_wf_o, disp_slot_o, rsp_id}); else passed++;
    rst = 1'b0;
    #1;
    total++; if (host_req_ready_o !== 1'b1) $display("FAIL reset_ready_after got %0b exp 1", host_req_ready_o); else passed++;
  endtask

  task automatic test_single();
    do_reset();
    push_req(15'd5, 4'd2);
    @(negedge clk);
    host_req_valid_i = 1'b0;
    #1;
    total++; if (disp_valid_o !== 1'b1) $display("FAIL single_disp_valid got %0b exp 1", disp_valid_o); else passed++;
    total++; if (disp_slot_o !== 2'd0) $display("FAIL single_slot got %0d exp 0", disp_slot_o); else passed++;
    total++; if (disp_wg_id_o !== 15'd5) $display("FAIL single_wg_id got %0d exp 5", disp_wg_id_o); else passed++;
    total++; if (disp_num_wf_o !== 4'd2) $display("FAIL single_num_wf got %0d exp 2", disp_num_wf_o); else passed++;
    disp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    disp_ready_i = 1'b0;
    wf_done_valid_i = 1'b1;
    wf_done_slot_i = 2'd0;
    @(posedge clk);
    @(negedge clk);
    #1;
    total++; if (host_rsp_valid_o !== 1'b0) $display("FAIL single_rsp_early got %0b exp 0", host_rsp_valid_o); else passed++;
    @(posedge clk);
    @(negedge clk);
    wf_done_valid_i = 1'b0;
    #1;
    total++; if (host_rsp_valid_o !== 1'b1) $display("FAIL single_rsp_valid got %0b exp 1", host_rsp_valid_o); else passed++;
    total++; if (rsp_id !== 15'd5) $display("FAIL single_rsp_id got %0d exp 5", rsp_id); else passed++;
    host_rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    host_rsp_ready_i = 1'b0;
    #1;
    total++; if (host_rsp_valid_o !== 1'b0) $display("FAIL single_rsp_drained got %0b exp 0", host_rsp_valid_o); else passed++;
    total++; if (err_o !== 1'b0) $display("FAIL single_err got %0b exp 0", err_o); else passed++;
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int i = 0; i < 4; i++) push_req(WGW'(10 + i), 4'd1);
    @(negedge clk);
    host_req_wg_id_i = 15'd20;
    #1;
    total++; if (host_req_ready_o !== 1'b0) $display("FAIL full_ready got %0b exp 0", host_req_ready_o); else passed++;
    total++; if (disp_wg_id_o !== 15'd10) $display("FAIL full_head got %0d exp 10", disp_wg_id_o); else passed++;
    @(posedge clk);
    @(negedge clk);
    #1;
    total++; if (host_req_ready_o !== 1'b0) $display("FAIL full_ready_held got %0b exp 0", host_req_ready_o); else passed++;
    disp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    disp_ready_i = 1'b0;
    #1;
    total++; if (host_req_ready_o !== 1'b1) $display("FAIL full_ready_freed got %0b exp 1", host_req_ready_o); else passed++;
    total++; if (disp_wg_id_o !== 15'd11) $display("FAIL full_next_head got %0d exp 11", disp_wg_id_o); else passed++;
    @(posedge clk);
    @(negedge clk);
    host_req_valid_i = 1'b0;
    #1;
    total++; if (host_req_ready_o !== 1'b0) $display("FAIL full_fifth_taken got %0b exp 0", host_req_ready_o); else passed++;
  endtask

  task automatic test_slots_full();
    logic [WGW-1:0] ids [5];
    ids = '{15'd1, 15'd2, 15'd3, 15'd4, 15'd6};
    do_reset();
    disp_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) push_req(ids[i], 4'd1);
    @(negedge clk);
    host_req_valid_i = 1'b0;
    #1;
    total++; if (disp_valid_o !== 1'b0) $display("FAIL slots_full_disp got %0b exp 0", disp_valid_o); else passed++;
    total++; if (host_rsp_valid_o !== 1'b0) $display("FAIL slots_full_rsp got %0b exp 0", host_rsp_valid_o); else passed++;
    wf_done_valid_i = 1'b1;
    wf_done_slot_i = 2'd2;
    @(posedge clk);
    @(negedge clk);
    wf_done_valid_i = 1'b0;
    disp_ready_i = 1'b0;
    #1;
    total++; if (host_rsp_valid_o !== 1'b1) $display("FAIL slots_rsp_valid got %0b exp 1", host_rsp_valid_o); else passed++;
    total++; if (rsp_id !== 15'd3) $display("FAIL slots_rsp_id got %0d exp 3", rsp_id); else passed++;
    total++; if (disp_valid_o !== 1'b1) $display("FAIL slots_redisp got %0b exp 1", disp_valid_o); else passed++;
    total++; if (disp_slot_o !== 2'd2) $display("FAIL slots_reslot got %0d exp 2", disp_slot_o); else passed++;
    total++; if (disp_wg_id_o !== 15'd6) $display("FAIL slots_reid got %0d exp 6", disp_wg_id_o); else passed++;
  endtask

  task automatic test_zero_wf();
    do_reset();
    push_req(15'd9, 4'd0);
    @(negedge clk);
    host_req_valid_i = 1'b0;
    #1;
    total++; if (disp_valid_o !== 1'b0) $display("FAIL zero_disp got %0b exp 0", disp_valid_o); else passed++;
    @(posedge clk);
    @(negedge clk);
    #1;
    total++; if (host_rsp_valid_o !== 1'b1) $display("FAIL zero_rsp_valid got %0b exp 1", host_rsp_valid_o); else passed++;
    total++; if (rsp_id !== 15'd9) $display("FAIL zero_rsp_id got %0d exp 9", rsp_id); else passed++;
    total++; if (disp_valid_o !== 1'b0) $display("FAIL zero_disp_after got %0b exp 0", disp_valid_o); else passed++;
  endtask

  task automatic test_err_and_reset();
    do_reset();
    @(negedge clk);
    wf_done_valid_i = 1'b1;
    wf_done_slot_i = 2'd3;
    @(posedge clk);
    @(negedge clk);
    wf_done_valid_i = 1'b0;
    #1;
    total++; if (err_o !== 1'b1) $display("FAIL err_set got %0b exp 1", err_o); else passed++;
    total++; if (host_rsp_valid_o !== 1'b0) $display("FAIL err_no_rsp got %0b exp 0", host_rsp_valid_o); else passed++;
    @(posedge clk);
    @(negedge clk);
    #1;
    total++; if (err_o !== 1'b1) $display("FAIL err_sticky got %0b exp 1", err_o); else passed++;
    disp_ready_i = 1'b1;
    push_req(15'd7, 4'd3);
    push_req(15'd8, 4'd3);
    @(negedge clk);
    host_req_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if ({host_req_ready_o, disp_valid_o, host_rsp_valid_o, err_o} !== 4'b0)
      $display("FAIL midrst_flags got %b exp 0000", {host_req_ready_o, disp_valid_o, host_rsp_valid_o, err_o}); else passed++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    host_rsp_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if ({disp_valid_o, host_rsp_valid_o, err_o, host_req_ready_o} !== 4'b0001)
        $display("FAIL postrst_state cyc %0d got %b exp 0001", i, {disp_valid_o, host_rsp_valid_o, err_o, host_req_ready_o}); else passed++;
      @(negedge clk);
    end
    host_rsp_ready_i = 1'b0;
  endtask

  task automatic model_update();
    int nvalid, pre;
    bit retire, zp, fire, pop;
    logic [WGW-1:0] rid, pid;
    req_t r;
    nvalid = 0;
    for (int i = 0; i < SLOTS; i++) nvalid += mv[i];
    retire = 0;
    rid = '0;
    if (wf_done_valid_i) begin
      if (mv[wf_done_slot_i]) begin
        if (mrem[wf_done_slot_i] == 1) begin
          retire = 1;
          rid = mid[wf_done_slot_i];
          mv[wf_done_slot_i] = 0;
        end else mrem[wf_done_slot_i]--;
      end else merr = 1;
    end
    zp = mq.size() > 0 && mq[0].nwf == 0 && !retire && (mrsp.size() + nvalid < SLOTS);
    fire = e_disp_valid && disp_ready_i;
    pop = e_rsp_valid && host_rsp_ready_i;
    pid = retire ? rid : (mq.size() > 0 ? mq[0].id : '0);
    pre = mrsp.size();
    if (pop) void'(mrsp.pop_front());
    if (retire || zp) begin
      if (pre == SLOTS && !pop) merr = 1;
      else mrsp.push_back(pid);
    end
    if (fire) begin
      r = mq.pop_front();
      mv[e_slot] = 1;
      mid[e_slot] = r.id;
      mrem[e_slot] = int'(r.nwf);
    end else if (zp) void'(mq.pop_front());
    have_offer = e_disp_valid && !disp_ready_i;
    offer = e_slot;
    if (host_req_valid_i && e_ready) begin
      r.id = host_req_wg_id_i;
      r.nwf = host_req_num_wf_i;
      r.cfg = host_req_cfg_i;
      mq.push_back(r);
    end
  endtask

  task automatic test_random();
    int lowest, vlist[$];
    bit any_free;
    do_reset();
    mq.delete();
    mrsp.delete();
    for (int i = 0; i < SLOTS; i++) begin mv[i] = 0; mrem[i] = 0; mid[i] = '0; end
    merr = 0;
    have_offer = 0;
    offer = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      host_req_valid_i  = ($urandom_range(0, 99) < 50);
      host_req_wg_id_i  = WGW'($urandom);
      host_req_num_wf_i = ($urandom_range(0, 9) == 0) ? '0 : WFW'($urandom_range(1, 3));
      for (int k = 0; k < CFG_W / 32; k++) host_req_cfg_i[k*32 +: 32] = $urandom;
      disp_ready_i     = ($urandom_range(0, 99) < 60);
      host_rsp_ready_i = ($urandom_range(0, 99) < 70);
      wf_done_valid_i  = ($urandom_range(0, 99) < 50);
      vlist.delete();
      for (int i = 0; i < SLOTS; i++) if (mv[i]) vlist.push_back(i);
      if (vlist.size() > 0 && $urandom_range(0, 59) != 0)
        wf_done_slot_i = SLOT_W'(vlist[$urandom_range(0, vlist.size() - 1)]);
      else
        wf_done_slot_i = SLOT_W'($urandom_range(0, SLOTS - 1));
      lowest = -1;
      for (int i = SLOTS - 1; i >= 0; i--) if (!mv[i]) lowest = i;
      any_free = (lowest >= 0);
      e_ready = (mq.size() < REQ_DEPTH);
      e_disp_valid = mq.size() > 0 && mq[0].nwf != 0 && any_free;
      e_slot = have_offer ? offer : lowest;
      e_rsp_valid = (mrsp.size() > 0);
      #1;
      total++; if (host_req_ready_o !== e_ready) $display("FAIL rnd_ready cyc %0d got %0b exp %0b", cyc, host_req_ready_o, e_ready); else passed++;
      total++; if (disp_valid_o !== e_disp_valid) $display("FAIL rnd_disp_valid cyc %0d got %0b exp %0b", cyc, disp_valid_o, e_disp_valid); else passed++;
      if (e_disp_valid) begin
        total++; if (disp_wg_id_o !== mq[0].id || disp_num_wf_o !== mq[0].nwf || disp_cfg_o !== mq[0].cfg)
          $display("FAIL rnd_disp_payload cyc %0d got id %0d nwf %0d exp id %0d nwf %0d", cyc, disp_wg_id_o, disp_num_wf_o, mq[0].id, mq[0].nwf); else passed++;
        total++; if (disp_slot_o !== SLOT_W'(e_slot)) $display("FAIL rnd_disp_slot cyc %0d got %0d exp %0d", cyc, disp_slot_o, e_slot); else passed++;
      end
      total++; if (host_rsp_valid_o !== e_rsp_valid) $display("FAIL rnd_rsp_valid cyc %0d got %0b exp %0b", cyc, host_rsp_valid_o, e_rsp_valid); else passed++;
      if (e_rsp_valid) begin
        total++; if (rsp_id !== mrsp[0]) $display("FAIL rnd_rsp_id cyc %0d got %0d exp %0d", cyc, rsp_id, mrsp[0]); else passed++;
      end
      total++; if (err_o !== merr) $display("FAIL rnd_err cyc %0d got %0b exp %0b", cyc, err_o, merr); else passed++;
      @(posedge clk);
      model_update();
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    test_reset();
    test_single();
    test_fifo_full();
    test_slots_full();
    test_zero_wf();
    test_err_and_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/host_wg_inflight_buf.md
HOST_WG_INFLIGHT_BUF -- requirements
Module: host_wg_inflight_buf

Interface
REQ-001 SHALL have parameter REQ_DEPTH, default 4, meaning request FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter SLOTS, default 4, meaning in-flight WG table entries (power of 2, >=2); SLOT_W = $clog2(SLOTS).
REQ-003 SHALL have parameter CFG_W, default 256, meaning width of packed kernel config (start_pc, pds/gds base, csr_knl, 3D size, GPR/LDS/GDS sizes).
REQ-004 SHALL use one clock, clk; reset is synchronous and active-high, named rst.
REQ-005 Ports: clk  in  1  clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 host_req_valid_i  in  1  host request valid.
REQ-008 host_req_ready_o  out  1  request FIFO not full.
REQ-009 host_req_wg_id_i  in  `WG_ID_WIDTH  work-group ID.
REQ-010 host_req_num_wf_i  in  `WF_COUNT_WIDTH  wavefronts in WG.
REQ-011 host_req_cfg_i  in  CFG_W  packed kernel config.
REQ-012 disp_valid_o / disp_ready_i  out/in  1  dispatcher handshake.
REQ-013 disp_wg_id_o, disp_num_wf_o, disp_cfg_o, disp_slot_o  out  same widths / SLOT_W  dispatched WG.
REQ-014 wf_done_valid_i  in  1, wf_done_slot_i  in  SLOT_W  one wavefront completion per cycle.
REQ-015 host_rsp_valid_o  out  1, host_rsp_ready_i  in  1, host_rsp_inflight_wg_buffer_host_wf_done_wg_id_o  out  `WG_ID_WIDTH  completed WG.
REQ-016 err_o  out  1  sticky protocol-error flag.

Function
REQ-017 Request FIFO SHALL push on host_req_valid_i && host_req_ready_o; host_req_ready_o = (count != REQ_DEPTH), registered count only (no same-cycle pop bypass).
REQ-018 disp_valid_o SHALL assert when FIFO non-empty, head num_wf != 0, and a free slot exists; payload = FIFO head; disp_slot_o = lowest-index free slot.
REQ-019 Request accepted in cycle N SHALL be visible on disp_* no earlier than N+1; disp_* SHALL be stable while disp_valid_o && !disp_ready_i.
REQ-020 On disp_valid_o && disp_ready_i: pop FIFO, mark slot valid, store wg_id, remaining = num_wf.
REQ-021 wf_done_valid_i to a valid slot SHALL decrement remaining; when remaining == 1, slot SHALL retire: wg_id pushed into response FIFO (depth SLOTS), slot freed.
REQ-022 A slot freed in cycle N SHALL NOT be allocated before N+1 (free mask registered).
REQ-023 Head with num_wf == 0 SHALL be popped without slot allocation and its wg_id pushed directly to response FIFO, only if (rsp_count + valid_slots) < SLOTS and no retire occurs that cycle; otherwise stall.
REQ-024 wf_done_valid_i to an invalid slot SHALL be ignored and set err_o until reset.
REQ-025 Response FIFO head SHALL drive host_rsp_*; pop on host_rsp_valid_o && host_rsp_ready_i; retire push in cycle N visible at N+1; simultaneous push/pop SHALL be lossless.
REQ-026 Response order SHALL be retirement order, not acceptance order.
REQ-027 FIFO pointers SHALL wrap modulo depth.

Reset
REQ-028 While rst high: both FIFOs empty, all slots invalid, err_o=0, host_req_ready_o=0, disp_valid_o=0, host_rsp_valid_o=0, data outputs 0.
REQ-029 host_req_ready_o SHALL be 1 the first cycle after rst deasserts; reset mid-operation SHALL discard all queued and in-flight WGs without emitting responses.

Configuration
REQ-030 With WG_BUF_STATS_EN defined: add outputs stat_wg_accepted_o and stat_wg_retired_o (32 bits each, reset 0, +1 per request handshake / response push, wrap at 2^32).
REQ-031 Without WG_BUF_STATS_EN: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-032 Single WG id=5, num_wf=2 -> disp_slot_o=0; two wf_done slot 0 -> host_rsp_valid_o next cycle, wg_id=5.
REQ-033 Push 4 WGs with disp_ready_i=0 -> host_req_ready_o=0 after 4th; fifth held until one dispatch.
REQ-034 Dispatch 4 WGs (ids 1-4, num_wf=1), fifth (id 6) waits; done slot 2 -> response id 3; id 6 dispatched slot 2 one cycle later.
REQ-035 num_wf=0, id=9, table empty -> response id 9, no disp_valid_o.
REQ-036 wf_done to empty slot 3 -> err_o=1 sticky, no response; rst mid-flight with 2 slots busy -> all outputs 0, no responses after.
